// File: rtl/interval_buf_pkg.sv
// interval_buf_pkg: shared sizes and helpers for the banked interval buffer (default geometry, rr_pick grant function, bank_of decode)
package interval_buf_pkg;
  localparam int IBUF_DATA_W = 32;
  localparam int IBUF_ADDR_W = 16;
  localparam int IBUF_BANK_W = 5;
  localparam int IBUF_NUM_PORTS = 8;
  localparam int IBUF_STAT_W = 32;
  localparam int BANKS = 2 ** IBUF_BANK_W;
  localparam int ROW_W = IBUF_ADDR_W - IBUF_BANK_W;
  localparam int MAX_P = 64;
  function automatic logic [MAX_P-1:0] rr_pick(input logic [MAX_P-1:0] req, input int ptr, input int n);
    logic [MAX_P-1:0] g;
    logic hit;
    int k;
    g = '0;
    hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      k = (ptr + i) % n;
      if (!hit && req[6'(k)]) begin
        g[6'(k)] = 1'b1;
        hit = 1'b1;
      end
    end
    return g;
  endfunction
  function automatic int bank_of(input logic [63:0] addr, input int bank_w);
    return int'(addr & ((64'(1) << bank_w) - 64'(1)));
  endfunction
endpackage

// File: rtl/ibuf_rr_arb.sv
// ibuf_rr_arb: N-way round-robin arbiter; clk, rst (async active-low), req in, one-hot gnt out, pointer moves past each winner
module ibuf_rr_arb
  import interval_buf_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [MAX_P-1:0] pick;
  always_comb begin
    pick = rr_pick(MAX_P'(req), int'(ptr), N);
    gnt = pick[N-1:0];
    ptr_nxt = ptr;
    for (int i = 0; i < N; i++)
      if (gnt[i]) ptr_nxt = PW'((i + 1) % N);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else ptr <= ptr_nxt;
endmodule

// File: rtl/interval_buffer_xn.sv
// interval_buffer_xn: banked multi-port interval buffer; clk, rst (async active-low), per-port r_valid/r_addr/r_ready -> r_out_valid/r_data, w_valid/w_addr/w_data/w_ready, stat_conf conflict counter; IBUF_WR_FWD_EN selects write-first same-row reads
module interval_buffer_xn
  import interval_buf_pkg::*;
#(
  parameter int DATA_W = IBUF_DATA_W,
  parameter int ADDR_W = IBUF_ADDR_W,
  parameter int BANK_W = IBUF_BANK_W,
  parameter int NUM_PORTS = IBUF_NUM_PORTS,
  parameter int STAT_W = IBUF_STAT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        r_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] r_addr,
  output logic [NUM_PORTS-1:0]        r_ready,
  output logic [NUM_PORTS-1:0]        r_out_valid,
  output logic [NUM_PORTS*DATA_W-1:0] r_data,
  input  logic [NUM_PORTS-1:0]        w_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] w_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] w_data,
  output logic [NUM_PORTS-1:0]        w_ready,
  output logic [STAT_W-1:0]           stat_conf
);
  localparam int NB = 2 ** BANK_W;
  localparam int RW = ADDR_W - BANK_W;
  localparam int DEPTH = 2 ** RW;
  logic [NB-1:0][NUM_PORTS-1:0] rreq, wreq, rgnt, wgnt;
  logic [NB-1:0][DATA_W-1:0] bank_q;
  logic [NUM_PORTS-1:0][BANK_W-1:0] rsel;
  logic conf;
  always_comb begin
    rreq = '0;
    wreq = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rreq[BANK_W'(bank_of(64'(r_addr[p*ADDR_W +: ADDR_W]), BANK_W))][p] = r_valid[p];
      wreq[BANK_W'(bank_of(64'(w_addr[p*ADDR_W +: ADDR_W]), BANK_W))][p] = w_valid[p];
    end
  end
  always_comb begin
    r_ready = '0;
    w_ready = '0;
    for (int b = 0; b < NB; b++) begin
      r_ready = r_ready | rgnt[b];
      w_ready = w_ready | wgnt[b];
    end
    conf = |(r_valid & ~r_ready) || |(w_valid & ~w_ready);
  end
  genvar b;
  generate
    for (b = 0; b < NB; b++) begin : g_bank
      logic [RW-1:0] rr, wr;
      logic [DATA_W-1:0] wd, q;
      logic we;
      logic [DATA_W-1:0] mem [DEPTH];
      ibuf_rr_arb #(.N(NUM_PORTS)) u_rarb (.clk(clk), .rst(rst), .req(rreq[b]), .gnt(rgnt[b]));
      ibuf_rr_arb #(.N(NUM_PORTS)) u_warb (.clk(clk), .rst(rst), .req(wreq[b]), .gnt(wgnt[b]));
      // Grants are one-hot, so an OR of masked fields selects the winner's row/data.
      always_comb begin
        rr = '0;
        wr = '0;
        wd = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          rr = rr | (rgnt[b][p] ? r_addr[p*ADDR_W+BANK_W +: RW] : '0);
          wr = wr | (wgnt[b][p] ? w_addr[p*ADDR_W+BANK_W +: RW] : '0);
          wd = wd | (wgnt[b][p] ? w_data[p*DATA_W +: DATA_W] : '0);
        end
        we = |wgnt[b];
      end
      // URAM-style bank: always enabled, read-old-data, contents never reset.
      always_ff @(posedge clk) begin
        if (we) mem[wr] <= wd;
        q <= mem[rr];
      end
`ifdef IBUF_WR_FWD_EN
      logic fwd;
      logic [DATA_W-1:0] wd_q;
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          fwd <= 1'b0;
          wd_q <= '0;
        end else begin
          fwd <= we && |rgnt[b] && rr == wr;
          wd_q <= wd;
        end
      assign bank_q[b] = fwd ? wd_q : q;
`else
      assign bank_q[b] = q;
`endif
    end
  endgenerate
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_out_valid <= '0;
      rsel <= '0;
      stat_conf <= '0;
    end else begin
      r_out_valid <= r_valid & r_ready;
      for (int p = 0; p < NUM_PORTS; p++) rsel[p] <= r_addr[p*ADDR_W +: BANK_W];
      if (conf && !(&stat_conf)) stat_conf <= stat_conf + 1'b1;
    end
  always_comb begin
    r_data = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      r_data[p*DATA_W +: DATA_W] = r_out_valid[p] ? bank_q[rsel[p]] : '0;
  end
endmodule

// File: tb/tb_interval_buffer_xn.sv
// tb_interval_buffer_xn: directed vector table plus multi-cycle sequences for interval_buffer_xn
module tb_interval_buffer_xn;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] r_valid, r_ready, r_out_valid, w_valid, w_ready;
  logic [127:0] r_addr, w_addr;
  logic [255:0] r_data, w_data;
  logic [3:0] stat_conf;
  int total = 0;
  int bad = 0;
`ifdef IBUF_WR_FWD_EN
  localparam logic [31:0] T4_EXP = 32'h1234;
`else
  localparam logic [31:0] T4_EXP = 32'h5555;
`endif
  interval_buffer_xn #(.STAT_W(4)) dut (
    .clk(clk), .rst(rst),
    .r_valid(r_valid), .r_addr(r_addr), .r_ready(r_ready),
    .r_out_valid(r_out_valid), .r_data(r_data),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .stat_conf(stat_conf)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] rv;
    logic [7:0][4:0] rb;
    logic [7:0] wv;
    logic [7:0][4:0] wb;
    logic [7:0] er;
    logic [7:0] ew;
    logic [3:0] ec;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    r_valid = '0;
    w_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  function automatic logic [15:0] mk(input int row, input int bank);
    return 16'((row << 5) | bank);
  endfunction
  initial begin
    rst = 1'b0;
    r_valid = '0;
    w_valid = '0;
    r_addr = '0;
    w_addr = '0;
    w_data = '0;
    tv[0] = '{8'hFF, {5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0}, 8'h00, 40'd0, 8'hFF, 8'h00, 4'd0};
    tv[1] = '{8'hFF, 40'd0, 8'h00, 40'd0, 8'h01, 8'h00, 4'd1};
    tv[2] = '{8'h0A, {5'd0,5'd0,5'd0,5'd0,5'd4,5'd0,5'd4,5'd0}, 8'h00, 40'd0, 8'h02, 8'h00, 4'd1};
    tv[3] = '{8'h00, 40'd0, 8'hFF, {5'd0,5'd1,5'd2,5'd3,5'd4,5'd5,5'd6,5'd7}, 8'h00, 8'hFF, 4'd0};
    tv[4] = '{8'h00, 40'd0, 8'hC0, {5'd31,5'd31,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 8'h00, 8'h40, 4'd1};
    tv[5] = '{8'h11, {5'd0,5'd0,5'd0,5'd2,5'd0,5'd0,5'd0,5'd1}, 8'h11, {5'd0,5'd0,5'd0,5'd1,5'd0,5'd0,5'd0,5'd1}, 8'h11, 8'h01, 4'd1};
    tv[6] = '{8'h00, 40'd0, 8'h00, 40'd0, 8'h00, 8'h00, 4'd0};
    tv[7] = '{8'h80, {5'd9,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 8'h80, {5'd9,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 8'h80, 8'h80, 4'd0};
    do_reset();
    #1;
    chk("rst_ovld", 64'(r_out_valid), 64'h0);
    chk("rst_rdata", 64'(r_data[63:0]), 64'h0);
    chk("rst_conf", 64'(stat_conf), 64'h0);
    chk("rst_rrdy", 64'(r_ready), 64'h0);
    chk("rst_wrdy", 64'(w_ready), 64'h0);
    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int p = 0; p < 8; p++) begin
        r_addr[p*16 +: 16] = mk(7, int'(tv[i].rb[p]));
        w_addr[p*16 +: 16] = mk(7, int'(tv[i].wb[p]));
        w_data[p*32 +: 32] = 32'(i * 16 + p);
      end
      r_valid = tv[i].rv;
      w_valid = tv[i].wv;
      #1;
      chk($sformatf("v%0d_rrdy", i), 64'(r_ready), 64'(tv[i].er));
      chk($sformatf("v%0d_wrdy", i), 64'(w_ready), 64'(tv[i].ew));
      @(negedge clk);
      chk($sformatf("v%0d_ovld", i), 64'(r_out_valid), 64'(tv[i].er));
      chk($sformatf("v%0d_conf", i), 64'(stat_conf), 64'(tv[i].ec));
      r_valid = '0;
      w_valid = '0;
    end
    // three writers on one bank/row
    do_reset();
    for (int p = 0; p < 3; p++) begin
      w_addr[p*16 +: 16] = 16'h0025;
      w_data[p*32 +: 32] = 32'hA + 32'(p);
    end
    w_valid = 8'h07;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t2_wrdy%0d", c), 64'(w_ready), 64'(1 << c));
      @(negedge clk);
      w_valid[c] = 1'b0;
    end
    chk("t2_conf", 64'(stat_conf), 64'd2);
    r_addr[15:0] = 16'h0025;
    r_valid = 8'h01;
    #1;
    chk("t2_rrdy", 64'(r_ready), 64'h01);
    @(negedge clk);
    r_valid = '0;
    chk("t2_ovld", 64'(r_out_valid), 64'h01);
    chk("t2_data", 64'(r_data[31:0]), 64'hC);
    // two readers sharing bank 2 alternate
    do_reset();
    r_addr[3*16 +: 16] = 16'h0002;
    r_addr[6*16 +: 16] = 16'h0002;
    r_valid = 8'h48;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("t3_rrdy%0d", c), 64'(r_ready), (c % 2) ? 64'h40 : 64'h08);
      @(negedge clk);
      chk($sformatf("t3_ovld%0d", c), 64'(r_out_valid), (c % 2) ? 64'h40 : 64'h08);
    end
    r_valid = '0;
    // same-cycle write and read of one row
    do_reset();
    w_addr[15:0] = 16'h0040;
    w_data[31:0] = 32'h5555;
    w_valid = 8'h01;
    @(negedge clk);
    w_data[31:0] = 32'h1234;
    r_addr[31:16] = 16'h0040;
    r_valid = 8'h02;
    #1;
    chk("t4_rrdy", 64'(r_ready), 64'h02);
    chk("t4_wrdy", 64'(w_ready), 64'h01);
    @(negedge clk);
    w_valid = '0;
    chk("t4_same", 64'(r_data[63:32]), 64'(T4_EXP));
    @(negedge clk);
    r_valid = '0;
    chk("t4_next", 64'(r_data[63:32]), 64'h1234);
    // reset with reads in flight
    do_reset();
    w_addr[47:32] = 16'h0061;
    w_data[95:64] = 32'hBEEF;
    w_valid = 8'h04;
    @(negedge clk);
    w_valid = '0;
    for (int p = 0; p < 4; p++) r_addr[p*16 +: 16] = mk(5, p);
    r_addr[4*16 +: 16] = 16'h000A;
    r_addr[5*16 +: 16] = 16'h000A;
    r_valid = 8'h3F;
    @(negedge clk);
    chk("t5_ovld", 64'(r_out_valid), 64'h1F);
    chk("t5_conf", 64'(stat_conf), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_ovld", 64'(r_out_valid), 64'h0);
    chk("t5_rst_conf", 64'(stat_conf), 64'h0);
    chk("t5_rst_data", 64'(r_data[63:0]), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    r_addr[15:0] = 16'h0061;
    r_valid = 8'h01;
    @(negedge clk);
    r_valid = '0;
    chk("t5_ovld2", 64'(r_out_valid), 64'h01);
    chk("t5_data", 64'(r_data[31:0]), 64'hBEEF);
    // conflict every cycle saturates the counter
    do_reset();
    r_addr[15:0] = 16'h0003;
    r_addr[31:16] = 16'h0003;
    r_valid = 8'h03;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 14) chk("t6_conf14", 64'(stat_conf), 64'hE);
      if (c == 15) chk("t6_conf15", 64'(stat_conf), 64'hF);
      if (c == 20) chk("t6_conf20", 64'(stat_conf), 64'hF);
    end
    r_valid = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
